// File: rtl/button_press_classifier.sv
`default_nettype none
// =============================================================================
// button_press_classifier
//   Turns a debounced button level into one single-cycle event per press:
//   short, long or (with macro DOUBLE_PRESS_EN) double press, plus a hold level.
//   Revision 1.0
// =============================================================================
module button_press_classifier #(
  parameter int unsigned LONG_TICKS = 50000000,
  parameter int unsigned GAP_TICKS  = 12500000,
  parameter int unsigned CNT_W      = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic debounced_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic holding
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRESSED   = 3'd1;
  localparam logic [2:0] S_LONG_HELD = 3'd2;
`ifdef DOUBLE_PRESS_EN
  localparam logic [2:0] S_WAIT_GAP  = 3'd3;
  localparam logic [2:0] S_SECOND    = 3'd4;
  localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(GAP_TICKS - 1);
`endif
  localparam logic [CNT_W-1:0] C_LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  // Reject parameter sets whose thresholds cannot be reached by the counter.
  if (LONG_TICKS < 2 || LONG_TICKS >= (64'd1 << CNT_W)) begin : g_long_range_err
    $error("LONG_TICKS out of range for CNT_W");
  end
  if (GAP_TICKS < 2 || GAP_TICKS >= (64'd1 << CNT_W)) begin : g_gap_range_err
    $error("GAP_TICKS out of range for CNT_W");
  end

  logic [2:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             short_d, short_q;
  logic             long_d, long_q;
  logic             double_d, double_q;
  logic             holding_d, holding_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (debounced_in) begin
          state_d = S_PRESSED;
          cnt_d   = C_ONE;
        end
      end
      S_PRESSED: begin
        if (debounced_in) begin
          if (cnt_q == C_LONG_LAST) begin
            state_d = S_LONG_HELD;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end else begin
`ifdef DOUBLE_PRESS_EN
          state_d = S_WAIT_GAP;
          cnt_d   = C_ONE;
`else
          state_d = S_IDLE;
          short_d = 1'b1;
`endif
        end
      end
      S_LONG_HELD: begin
        if (!debounced_in) begin
          state_d = S_IDLE;
        end
      end
`ifdef DOUBLE_PRESS_EN
      S_WAIT_GAP: begin
        if (debounced_in) begin
          state_d  = S_SECOND;
          double_d = 1'b1;
        end else if (cnt_q == C_GAP_LAST) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      // Long detection is deliberately off here: the press already became a double.
      S_SECOND: begin
        if (!debounced_in) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    holding_d = (state_d == S_LONG_HELD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
      holding_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      short_q   <= short_d;
      long_q    <= long_d;
      double_q  <= double_d;
      holding_q <= holding_d;
    end
  end

  assign short_press = short_q;
  assign long_press  = long_q;
  assign holding     = holding_q;
`ifdef DOUBLE_PRESS_EN
  assign double_press = double_q;
`else
  assign double_press = 1'b0;
  logic unused_double;
  assign unused_double = double_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_press_classifier.sv
`default_nettype none
// Scoreboard bench for button_press_classifier with LONG_TICKS=8, GAP_TICKS=6.
module tb_button_press_classifier;

  localparam logic [2:0] K_SHORT  = 3'd0;
  localparam logic [2:0] K_LONG   = 3'd1;
  localparam logic [2:0] K_DOUBLE = 3'd2;
  localparam logic [2:0] K_HRISE  = 3'd3;
  localparam logic [2:0] K_HFALL  = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    int         stamp;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n;
  logic debounced_in;
  logic short_press, long_press, double_press, holding;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic hold_prev = 1'b0;
  ev_t  exp_q[$];

  button_press_classifier #(
    .LONG_TICKS(8),
    .GAP_TICKS (6),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .debounced_in(debounced_in),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .holding     (holding)
  );

  always #5 clk = ~clk;

  // cyc == k once the k-th rising edge has happened
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input logic [2:0] k, input int s);
    ev_t e;
    e.kind  = k;
    e.stamp = s;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input logic [2:0] k, input string name);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: seen at edge %0d, required no event", name, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.stamp != cyc) begin
        bad++;
        $display("FAIL event_%s: got kind=%0d edge=%0d, required kind=%0d edge=%0d",
                 name, k, cyc, e.kind, e.stamp);
      end
    end
  endtask

  task automatic check_lvl(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per observed event.
  always @(negedge clk) begin
    total++;
    if ((int'(short_press) + int'(long_press) + int'(double_press)) > 1) begin
      bad++;
      $display("FAIL exclusive: edge %0d pulses s/l/d=%b%b%b, required at most one",
               cyc, short_press, long_press, double_press);
    end
    if (short_press === 1'b1)  check_ev(K_SHORT,  "short");
    if (long_press === 1'b1)   check_ev(K_LONG,   "long");
    if (double_press === 1'b1) check_ev(K_DOUBLE, "double");
    if (holding !== hold_prev) check_ev(holding ? K_HRISE : K_HFALL, "holding");
    hold_prev <= holding;
  end

  // Each iteration presents a level that is sampled by the next rising edge.
  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      debounced_in = lvl;
      @(negedge clk);
    end
  endtask

  initial begin
    int b;
    reset_n      = 1'b0;
    debounced_in = 1'b1;
    repeat (3) @(negedge clk);
    check_lvl("rst_short",   short_press,  1'b0);
    check_lvl("rst_long",    long_press,   1'b0);
    check_lvl("rst_double",  double_press, 1'b0);
    check_lvl("rst_holding", holding,      1'b0);

    // Input high through reset release: fresh press, long after the 8th edge
    reset_n = 1'b1;
    b = cyc + 1;
    push(K_LONG, b + 7);
    push(K_HRISE, b + 7);
    drive(1'b1, 10);

    // One-edge reset during LONG_HELD: holding drops, no event, recount from 1
    reset_n = 1'b0;
    push(K_HFALL, cyc + 1);
    drive(1'b1, 1);
    reset_n = 1'b1;
    b = cyc + 1;
    push(K_LONG, b + 7);
    push(K_HRISE, b + 7);
    drive(1'b1, 9);
    push(K_HFALL, cyc + 1);
    drive(1'b0, 4);

    // High 7 edges: one short of long
    b = cyc + 1;
`ifdef DOUBLE_PRESS_EN
    push(K_SHORT, b + 12);
`else
    push(K_SHORT, b + 7);
`endif
    drive(1'b1, 7);
    drive(1'b0, 8);

    // High 20 edges: long, holding until one cycle after release, no short
    b = cyc + 1;
    push(K_LONG, b + 7);
    push(K_HRISE, b + 7);
    push(K_HFALL, b + 20);
    drive(1'b1, 20);
    drive(1'b0, 3);

    // High exactly 8 edges: boundary that qualifies as long
    b = cyc + 1;
    push(K_LONG, b + 7);
    push(K_HRISE, b + 7);
    push(K_HFALL, b + 8);
    drive(1'b1, 8);
    drive(1'b0, 3);

    // High 3, low 5, high 3, low 10
    b = cyc + 1;
`ifdef DOUBLE_PRESS_EN
    push(K_DOUBLE, b + 8);
`else
    push(K_SHORT, b + 3);
    push(K_SHORT, b + 11);
`endif
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, 3);
    drive(1'b0, 10);

    // High 3, low 6: gap window closes on the 6th low edge
    b = cyc + 1;
`ifdef DOUBLE_PRESS_EN
    push(K_SHORT, b + 8);
`else
    push(K_SHORT, b + 3);
`endif
    drive(1'b1, 3);
    drive(1'b0, 8);

    drive(1'b0, 5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: %0d expected events never seen, first due at edge %0d kind %0d",
               exp_q.size(), exp_q[0].stamp, exp_q[0].kind);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_press_classifier.md
# button_press_classifier

Event classifier downstream of the switch debouncer. Consumes the clean debounced level and turns each press into exactly one single-cycle event: short press, long press or (optionally) double press. Also provides a hold level while a long press continues. Event pulses drive the menu and mode-control logic directly, so no further edge detection is needed there.

## Interface
- Parameters:
  - `LONG_TICKS`, default 50000000: number of consecutive sampled-high cycles that qualify a press as long. Legal range 2 ≤ `LONG_TICKS` < 2^`CNT_W`.
  - `GAP_TICKS`, default 12500000: number of consecutive sampled-low cycles after a short release that closes the double-press window. Legal range 2 ≤ `GAP_TICKS` < 2^`CNT_W`.
  - `CNT_W`, default 27: width of the internal tick counter.
- Ports:
  - `clk`  input  1  single clock; all logic on the rising edge.
  - `reset_n`  input  1  synchronous, active-low reset.
  - `debounced_in`  input  1  clean button level from the debouncer, already synchronous to `clk`; 1 = pressed.
  - `short_press`  output  1  one-cycle pulse for a short press.
  - `long_press`  output  1  one-cycle pulse when a press becomes long, issued while the button is still held.
  - `double_press`  output  1  one-cycle pulse when a second press starts inside the gap window. Tied 0 when `DOUBLE_PRESS_EN` is undefined.
  - `holding`  output  1  level; high while in LONG_HELD.

## Operation
- All outputs are registered.
- One internal counter `cnt`, `CNT_W` bits, loaded as stated on each transition.
- States:
  - IDLE
    - `debounced_in`=1 → PRESSED, cnt=1.
  - PRESSED
    - in=1 and cnt==LONG_TICKS-1 → LONG_HELD; pulse `long_press`.
    - in=1 otherwise → cnt++.
    - in=0, `DOUBLE_PRESS_EN` undefined → IDLE; pulse `short_press`.
    - in=0, `DOUBLE_PRESS_EN` defined → WAIT_GAP, cnt=1.
  - LONG_HELD
    - `holding`=1.
    - in=0 → IDLE; no pulse on release.
  - WAIT_GAP
    - in=1 → SECOND; pulse `double_press`.
    - in=0 and cnt==GAP_TICKS-1 → IDLE; pulse `short_press`.
    - in=0 otherwise → cnt++.
  - SECOND
    - Waits for release; long detection is disabled here.
    - in=0 → IDLE; no pulse.
- Classification rule: a press high for H consecutive sampled edges is long iff H ≥ `LONG_TICKS`.
- The three event pulses are mutually exclusive; at most one is high in any cycle.
- Each press produces exactly one event. Double press replaces both short presses.
- Unreachable state encodings → IDLE on the next edge, with outputs 0.

## Timing
- Reset:
  - `reset_n`=0 sampled on an edge → state IDLE, cnt=0.
  - All outputs are 0 after that edge: `short_press`, `long_press`, `double_press` and `holding`.
  - Reset mid-operation aborts any pending event. No pulse is issued for an interrupted press.
- Input held high through reset release: the first edge with `reset_n`=1 samples it as a fresh press (cnt=1).
- Pulse latency: each pulse is high for exactly the one cycle following the edge on which its transition is taken.
- `long_press`: rises one cycle after the `LONG_TICKS`-th consecutive high edge.
- `holding`:
  - Rises together with `long_press`.
  - Falls one cycle after the first low edge.
- `short_press` without the macro: one cycle after the release edge.
- `short_press` with the macro: one cycle after the `GAP_TICKS`-th consecutive low edge. The release edge counts as the first low edge.
- Second press on low edge k < `GAP_TICKS`+1 after release → `double_press`.

## Configuration
- `DOUBLE_PRESS_EN`
  - Defined: WAIT_GAP and SECOND exist. Short presses are delayed by the gap window, and double presses are detected.
  - Undefined: those states and their logic are removed, `double_press` is constant 0, and a short release goes straight to IDLE with an immediate `short_press`.

## Test plan
- Common settings: `LONG_TICKS`=8, `GAP_TICKS`=6.
- Reset: hold `reset_n`=0 for 3 cycles with `debounced_in`=1 → all outputs 0. After release, keep the input high for 8 edges → `long_press`=1 for exactly 1 cycle after the 8th edge; `holding`=1 from that cycle.
- Macro undefined: input high for 7 edges, then low → `short_press`=1 for 1 cycle after the first low edge; `long_press` never asserts.
- Long press: input high for 20 edges, then low → `long_press` fires once; `holding` stays 1 until one cycle after the first low edge. No `short_press` follows.
- Macro defined:
  - High 3, low 5, high 3, low 10 → single `double_press` one cycle after the second rise. No `short_press`.
  - High 3, low 6 → `short_press` after the 6th low edge.
- Assert `reset_n`=0 for 1 edge during LONG_HELD → `holding`=0 next cycle and no event fires. With input still high, a new long press is counted from 1.
